// File: rtl/maku_pkg.sv
// rtl/maku_pkg.sv - shared address map, error pattern and responder FSM states
package maku_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] PER_BASE    = 32'h4000_0000;
    localparam logic [31:0] PER_SIZE    = 32'h0000_0100;
    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        RAM_RD,
        PER_REQ,
        PER_WAIT,
        RESP
    } state_t;

    // ram_limit is the RAM size in bytes, widened so a full 4 GiB map still fits
    function automatic logic in_ram(input logic [31:0] a, input logic [32:0] ram_limit);
        logic [32:0] offset;
        offset = {1'b0, a - RAM_BASE};
        return offset < ram_limit;
    endfunction

    function automatic logic in_per(input logic [31:0] a);
        return (a - PER_BASE) < PER_SIZE;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - single-port data RAM, byte write enables, 1-cycle synchronous read
module dmem_bram #(
    parameter int WORDS = 4096,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Contents are deliberately not reset so data survives a responder reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/gp_data_bus_responder.sv
// rtl/gp_data_bus_responder.sv - GP data port responder (RAM, peripheral window, unmapped); MAKU_BUS_TIMEOUT_EN adds a peripheral timeout
module gp_data_bus_responder
    import maku_pkg::*;
#(
    parameter int RAM_WORDS   = 4096,
    parameter int PER_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        bus_err,
    output logic        reg_en,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ready
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) * 33'd4;

    state_t      state, state_next;
    logic        op_we, op_we_next;
    logic        ready_next, bus_err_next;
    logic [31:0] rdata_next;
    logic        reg_en_next, reg_we_next;
    logic [7:0]  reg_addr_next;
    logic [31:0] reg_wdata_next;

    logic        hit_ram, hit_per, accept;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    assign hit_ram = in_ram(addr, RAM_LIMIT);
    assign hit_per = in_per(addr);
    assign accept  = (state == IDLE) && req;
    assign ram_en  = accept && hit_ram;
    assign ram_we  = be & {4{we}};

    dmem_bram #(.WORDS(RAM_WORDS)) u_dmem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr[AW+1:2]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

`ifdef MAKU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(PER_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic          timed_out;
    // wait_cnt counts cycles since the reg_en cycle
    assign timed_out = (wait_cnt == CW'(PER_TIMEOUT - 1));
`endif

    always_comb begin
        state_next     = state;
        op_we_next     = op_we;
        ready_next     = 1'b0;
        bus_err_next   = 1'b0;
        rdata_next     = '0;
        reg_en_next    = 1'b0;
        reg_we_next    = 1'b0;
        reg_addr_next  = '0;
        reg_wdata_next = '0;
`ifdef MAKU_BUS_TIMEOUT_EN
        wait_cnt_next  = '0;
`endif
        case (state)
            IDLE: begin
                if (req) begin
                    op_we_next = we;
                    if (hit_ram) begin
                        if (we) begin
                            state_next = RESP;
                            ready_next = 1'b1;
                        end else begin
                            state_next = RAM_RD;
                        end
                    end else if (hit_per) begin
                        state_next     = PER_REQ;
                        reg_en_next    = 1'b1;
                        reg_we_next    = we;
                        reg_addr_next  = addr[7:0];
                        reg_wdata_next = wdata;
                    end else begin
                        state_next   = RESP;
                        ready_next   = 1'b1;
                        bus_err_next = 1'b1;
                        rdata_next   = ERR_PATTERN;
                    end
                end
            end
            RAM_RD: begin
                state_next = RESP;
                ready_next = 1'b1;
                rdata_next = ram_rdata;
            end
            PER_REQ, PER_WAIT: begin
`ifdef MAKU_BUS_TIMEOUT_EN
                wait_cnt_next = wait_cnt + CW'(1);
`endif
                if (reg_ready) begin
                    state_next = RESP;
                    ready_next = 1'b1;
                    rdata_next = op_we ? 32'h0 : reg_rdata;
`ifdef MAKU_BUS_TIMEOUT_EN
                end else if (timed_out) begin
                    state_next   = RESP;
                    ready_next   = 1'b1;
                    bus_err_next = 1'b1;
                    rdata_next   = ERR_PATTERN;
`endif
                end else begin
                    state_next = PER_WAIT;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            ready     <= 1'b0;
            bus_err   <= 1'b0;
            rdata     <= '0;
            reg_en    <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_next;
            op_we     <= op_we_next;
            ready     <= ready_next;
            bus_err   <= bus_err_next;
            rdata     <= rdata_next;
            reg_en    <= reg_en_next;
            reg_we    <= reg_we_next;
            reg_addr  <= reg_addr_next;
            reg_wdata <= reg_wdata_next;
        end
    end

`ifdef MAKU_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_gp_data_bus_responder.sv
// tb/tb_gp_data_bus_responder.sv - scoreboard bench for gp_data_bus_responder
module tb_gp_data_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n, req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata, reg_wdata, reg_rdata;
    logic        ready, bus_err, reg_en, reg_we, reg_ready;
    logic [7:0]  reg_addr;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb[$];

    bit          per_active;
    int          per_delay;
    logic [31:0] per_data;
    int          en_cycles = 0;
    logic [7:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;

    gp_data_bus_responder #(.RAM_WORDS(4096), .PER_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .bus_err   (bus_err),
        .reg_en    (reg_en),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every cycle reg_en is high counts, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (reg_en === 1'b1) begin
            en_cycles++;
            cap_addr  = reg_addr;
            cap_we    = reg_we;
            cap_wdata = reg_wdata;
        end
    end

    initial begin
        reg_ready = 1'b0;
        reg_rdata = '0;
        forever begin
            @(negedge clk);
            if (reg_en === 1'b1 && per_active) begin
                repeat (per_delay) @(negedge clk);
                reg_ready = 1'b1;
                reg_rdata = per_data;
                @(negedge clk);
                reg_ready = 1'b0;
                reg_rdata = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        exp_t e;
        int   lat;
        bit   quiet;
        sb.push_back('{rdata: exp_rd, err: exp_err, lat: 8'(exp_lat)});
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        lat = 0;
        quiet = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (ready !== 1'b1 && (rdata !== 32'h0 || bus_err !== 1'b0)) quiet = 1'b0;
        end while (ready !== 1'b1 && lat < 64);
        req = 1'b0;
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " rdata"}, rdata, e.rdata);
        check({tag, " bus_err"}, 32'(bus_err), 32'(e.err));
        check({tag, " idle outputs"}, 32'(quiet), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, 32'(ready), 32'd0);
        check({tag, " bus_err"}, 32'(bus_err), 32'd0);
        check({tag, " rdata"}, rdata, 32'd0);
        check({tag, " reg_en"}, 32'(reg_en), 32'd0);
        check({tag, " reg_we"}, 32'(reg_we), 32'd0);
        check({tag, " reg_addr"}, 32'(reg_addr), 32'd0);
        check({tag, " reg_wdata"}, reg_wdata, 32'd0);
    endtask

    initial begin
        int en0;
        int stray;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        per_active = 1'b1; per_delay = 0; per_data = '0;
        @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        access("wr10", 1'b1, 4'hF, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 1);
        access("rd10", 1'b0, 4'hF, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2);
        access("wr10_be5", 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD, 32'h0, 1'b0, 1);
        access("rd10_be5", 1'b0, 4'hF, 32'h10, 32'h0, 32'h11BB_33DD, 1'b0, 2);
        access("wr10_be0", 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        access("rd10_be0", 1'b0, 4'hF, 32'h10, 32'h0, 32'h11BB_33DD, 1'b0, 2);
        access("rd13_lowbits", 1'b0, 4'hF, 32'h13, 32'h0, 32'h11BB_33DD, 1'b0, 2);
        access("wr_top", 1'b1, 4'hF, 32'h3FFC, 32'h5A5A_0F0F, 32'h0, 1'b0, 1);
        access("rd_top", 1'b0, 4'hF, 32'h3FFC, 32'h0, 32'h5A5A_0F0F, 1'b0, 2);
        access("rd_zero", 1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0, 2);

        en0 = en_cycles;
        access("unmap_ram_end", 1'b0, 4'hF, 32'h4000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);
        access("unmap_8000", 1'b0, 4'hF, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);
        access("unmap_per_end", 1'b1, 4'hF, 32'h4000_0100, 32'h1, 32'hDEAD_BEEF, 1'b1, 1);
        check("unmap reg_en count", 32'(en_cycles - en0), 32'd0);
        access("rd_top_after_unmap", 1'b0, 4'hF, 32'h3FFC, 32'h0, 32'h5A5A_0F0F, 1'b0, 2);

        per_delay = 3; per_data = 32'h0000_00A5;
        en0 = en_cycles;
        access("per_rd08", 1'b0, 4'hF, 32'h4000_0008, 32'h0, 32'h0000_00A5, 1'b0, 5);
        check("per_rd08 reg_en cycles", 32'(en_cycles - en0), 32'd1);
        check("per_rd08 reg_addr", 32'(cap_addr), 32'h08);
        check("per_rd08 reg_we", 32'(cap_we), 32'd0);

        per_delay = 0; per_data = 32'h1234_5678;
        en0 = en_cycles;
        access("per_wrFC", 1'b1, 4'b0001, 32'h4000_00FC, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
        check("per_wrFC reg_en cycles", 32'(en_cycles - en0), 32'd1);
        check("per_wrFC reg_addr", 32'(cap_addr), 32'hFC);
        check("per_wrFC reg_we", 32'(cap_we), 32'd1);
        check("per_wrFC reg_wdata", cap_wdata, 32'hCAFE_F00D);

        per_active = 1'b0;
`ifdef MAKU_BUS_TIMEOUT_EN
        access("per_timeout", 1'b0, 4'hF, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 17);
`endif
        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h4000_0010; wdata = '0;
        stray = 0;
`ifdef MAKU_BUS_TIMEOUT_EN
        repeat (5) begin
`else
        repeat (100) begin
`endif
            @(negedge clk);
            if (ready === 1'b1) stray++;
        end
        check("per_hang no ready", 32'(stray), 32'd0);

        rst_n = 1'b0;
        req = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready === 1'b1) stray++;
        end
        check("post_reset no stale ready", 32'(stray), 32'd0);
        access("rd10_after_reset", 1'b0, 4'hF, 32'h10, 32'h0, 32'h11BB_33DD, 1'b0, 2);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gp_data_bus_responder.md
GP_DATA_BUS_RESPONDER -- requirements
Module: gp_data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, data RAM depth in 32-bit words (16 KiB).
REQ-002 SHALL have parameter PER_TIMEOUT, default 16, peripheral wait limit in cycles (used only when the Configuration macro is defined).
REQ-003 clk  input  1  single clock (GP domain, 100 MHz); one clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  1  request from GP data port; requester holds req/we/be/addr/wdata stable until ready.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 be  input  4  byte enables, be[i] covers wdata[8i+7:8i].
REQ-008 addr  input  32  byte address; addr[1:0] ignored (word access).
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data, valid only in the ready cycle.
REQ-011 ready  output  1  one-cycle completion pulse, registered.
REQ-012 bus_err  output  1  one-cycle pulse coincident with ready on a failed access.
REQ-013 reg_en  output  1  peripheral access strobe, one cycle.
REQ-014 reg_we  output  1  peripheral write qualifier.
REQ-015 reg_addr  output  8  peripheral register byte offset = addr[7:0].
REQ-016 reg_wdata  output  32  peripheral write data.
REQ-017 reg_rdata  input  32  peripheral read data, sampled when reg_ready=1.
REQ-018 reg_ready  input  1  peripheral completion.

Function
REQ-019 Address map SHALL be: RAM 0x0000_0000..RAM_WORDS*4-1; peripheral window 0x4000_0000..0x4000_00FF; all else unmapped.
REQ-020 FSM states SHALL be IDLE, RAM_RD, PER_REQ, PER_WAIT, RESP; requests are accepted only in IDLE.
REQ-021 IDLE & req & RAM & we: bytes with be[i]=1 written at accept edge; go RESP; ready at cycle 1 (accept = cycle 0).
REQ-022 IDLE & req & RAM & !we: go RAM_RD (synchronous BRAM read), then RESP; ready and rdata at cycle 2.
REQ-023 be=4'b0000 write SHALL leave RAM unchanged and still complete with ready at cycle 1.
REQ-024 IDLE & req & peripheral: go PER_REQ, driving reg_en=1, reg_we=we, reg_addr, reg_wdata for exactly one cycle; then PER_WAIT until reg_ready=1, capture reg_rdata, go RESP.
REQ-025 reg_ready seen in the PER_REQ cycle SHALL be honoured (direct to RESP); peripheral writes ignore be.
REQ-026 IDLE & req & unmapped: go RESP with rdata=0xDEAD_BEEF, bus_err=1, no RAM/peripheral side effect.
REQ-027 RESP SHALL assert ready for exactly one cycle and return to IDLE; IDLE ignores req for that cycle, so the minimum issue interval is 2 cycles (write) / 3 cycles (read).
REQ-028 rdata SHALL be 0 outside the ready cycle; write completions return rdata=0.
REQ-029 Changes on req/addr while not in IDLE SHALL be ignored.

Reset
REQ-030 On rst_n=0 SHALL immediately force IDLE, ready=0, bus_err=0, rdata=0, reg_en=0, reg_we=0, reg_addr=0, reg_wdata=0, timeout counter=0.
REQ-031 RAM contents SHALL NOT be reset; a write completed at an edge before reset persists; an in-flight read or peripheral access is abandoned without ready.

Configuration
REQ-032 Macro MAKU_BUS_TIMEOUT_EN defined: counter in PER_WAIT; if reg_ready is not seen within PER_TIMEOUT cycles after reg_en, go RESP with rdata=0xDEAD_BEEF, bus_err=1; a late reg_ready is ignored.
REQ-033 Macro undefined: PER_WAIT waits indefinitely, no counter logic synthesised, bus_err only for unmapped addresses.

Structure
REQ-034 Address-map base/size constants, the 0xDEAD_BEEF error pattern and the FSM state enum SHALL reside in shared package maku_pkg.
REQ-035 RAM SHALL be a sub-module dmem_bram (single-port, byte-write-enable, 1-cycle synchronous read, BRAM-inferable).

Verification
REQ-036 Write addr=0x10, wdata=0x1122_3344, be=4'hF, then read 0x10 -> ready at cycle 1 for the write; read returns 0x1122_3344 at cycle 2.
REQ-037 Write be=4'b0101, wdata=0xAABB_CCDD over 0x1122_3344 at 0x10; read -> 0x11BB_33DD.
REQ-038 Read 0x4000_0008, peripheral reg_ready after 3 cycles with reg_rdata=0x0000_00A5 -> reg_en one cycle with reg_addr=0x08, ready with rdata=0x0000_00A5, bus_err=0.
REQ-039 Read 0x8000_0000 -> ready at cycle 1, rdata=0xDEAD_BEEF, bus_err=1, reg_en never asserted.
REQ-040 MAKU_BUS_TIMEOUT_EN, PER_TIMEOUT=16, reg_ready held 0 -> ready and bus_err 16 cycles after reg_en, rdata=0xDEAD_BEEF; without macro, no ready after 100 cycles.
REQ-041 Assert rst_n=0 in PER_WAIT, release, issue read 0x10 -> no stale ready; outputs zero during reset; read returns the prior RAM value.
